alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Command-side initiator for the 8-bit main_ALU responder. Accepts one operation per valid/ready
//  handshake, drives opcode/operands, holds them stable for the opcode's fixed latency, captures
//  Y/Z/O/C and returns them on a valid/ready response channel. Sits between control logic and main_ALU.
// PARAMETERS
//  DATA_W       8    operand/result half width (matches main_ALU)
//  ALU_LAT      2    clock cycles from operand drive to valid result, opcodes 00/01/10
//  MUL_LAT      26   clock cycles from operand drive to valid result, opcode 11 (multi-cycle multiply)
// PORTS
//  clock        in   1         single clock, rising edge
//  reset        in   1         asynchronous, active-high
//  cmd_valid    in   1         command present
//  cmd_ready    out  1         sequencer can accept command
//  cmd_op       in   2         opcode: 00 add, 01 sub, 10 op2, 11 multiply
//  cmd_a        in   DATA_W    operand A
//  cmd_b        in   DATA_W    operand B
//  alu_opcode   out  2         to main_ALU OPCode
//  alu_a        out  DATA_W    to main_ALU A
//  alu_b        out  DATA_W    to main_ALU B
//  alu_y        in   DATA_W    from main_ALU Y (low result)
//  alu_z        in   DATA_W    from main_ALU Z (high result, multiply)
//  alu_o        in   1         from main_ALU O (overflow)
//  alu_c        in   1         from main_ALU C (carry)
//  rsp_valid    out  1         response present
//  rsp_ready    in   1         consumer accepts response
//  rsp_data     out  2*DATA_W  {Z,Y}; Z forced 0 for opcodes 00/01/10
//  rsp_o        out  1         captured overflow
//  rsp_c        out  1         captured carry
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, cmd_ready=1, rsp_valid=0, alu_opcode/alu_a/alu_b=0,
//    rsp_data=0, rsp_o=0, rsp_c=0, latency counter=0.
//  - FSM: IDLE -> WAIT on cmd_valid&cmd_ready; registers op/A/B onto alu_* outputs that edge.
//    WAIT: counter loaded with (op==11 ? MUL_LAT : ALU_LAT)-1, decrements each cycle; alu_* held
//    constant. At counter==0 capture alu_y/z/o/c into rsp_* -> RESP, rsp_valid=1 next cycle.
//    RESP: hold rsp_* stable until rsp_valid&rsp_ready; then -> IDLE, rsp_valid=0.
//  - cmd_ready=1 only in IDLE; one op in flight, no overlap. Command-to-response = LAT+1 cycles.
//  - rsp_data/o/c remain stable while rsp_valid=1 and rsp_ready=0 (indefinite backpressure OK).
//  - alu_* keep last operation after completion (no return to 0) to avoid spurious ALU activity.
//  - cmd_valid while not ready: ignored, no sampling; caller must hold until accepted.
//  - Reset mid-WAIT or mid-RESP: operation dropped, no response emitted, outputs to reset values.
//  - Counter width = clog2(max(ALU_LAT,MUL_LAT)); LAT values <1 are illegal (elaboration error).
// CONFIGURATION
//  ALU_SEQ_STATS_EN defined: adds outputs stat_ops[15:0] (completed responses, incremented on
//    rsp handshake) and stat_ovf[15:0] (responses with rsp_o=1); both reset 0, wrap at 0xFFFF.
//  Not defined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  - Package alu_seq_pkg: opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_2=2'b10, OP_MUL=2'b11;
//    state encoding S_IDLE, S_WAIT, S_RESP; function lat_for(op) returning cycle count.
//  - One natural sub-module: alu_seq_lat_cnt (loadable down-counter with zero flag).
// TESTING (bench instantiates main_ALU as responder; 10 ns clock)
//  1. op=00, A=0x13, B=0x2C -> rsp_data=0x003F, O=0, C=0 after ALU_LAT+1 cycles.
//  2. op=00, A=0x7F, B=0x05 -> rsp_data=0x0084, O=1.
//  3. op=11, A=0x04, B=0x03 -> rsp_valid only after MUL_LAT+1 cycles, rsp_data=0x000C.
//  4. op=11, A=0x7F, B=0x08, rsp_ready low 10 cycles -> rsp_data=0x03F8 held stable, cmd_ready=0.
//  5. op=01, A=0x7F, B=0x01; assert reset during WAIT -> no rsp_valid, all outputs reset values,
//     new command accepted first cycle after reset release.
//  6. ALU_SEQ_STATS_EN: run scenarios 1-4 -> stat_ops=4, stat_ovf=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_op_sequencer: main_ALU opcodes, FSM states and
// the per-opcode latency lookup.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_2   = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam int ALU_LAT_DEF = 2;
  localparam int MUL_LAT_DEF = 26;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Cycles from operand drive until main_ALU presents a valid result.
  function automatic int lat_for(input logic [1:0] op,
                                 input int alu_lat = ALU_LAT_DEF,
                                 input int mul_lat = MUL_LAT_DEF);
    return (op == OP_MUL) ? mul_lat : alu_lat;
  endfunction

endpackage

// File: rtl/alu_seq_lat_cnt.sv
// Loadable down-counter that stops at zero and flags it; times the main_ALU
// result latency for alu_op_sequencer.
module alu_seq_lat_cnt
  import alu_seq_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Single-outstanding command sequencer for main_ALU: drives and holds operands
// for the opcode latency, then returns {Z,Y},O,C on a valid/ready channel.
// Define ALU_SEQ_STATS_EN to add stat_ops/stat_ovf response counters.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ALU_LAT = ALU_LAT_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  output logic [1:0]          alu_opcode,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_y,
  input  logic [DATA_W-1:0]   alu_z,
  input  logic                alu_o,
  input  logic                alu_c,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                rsp_o,
  output logic                rsp_c
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]         stat_ops,
  output logic [15:0]         stat_ovf
`endif
);

  localparam int MAX_LAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  if (ALU_LAT < 1 || MUL_LAT < 1) begin : g_bad_lat
    $error("alu_op_sequencer: ALU_LAT and MUL_LAT must both be >= 1");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_capture;
  logic               w_rsp_hs;
  logic               w_cnt_dec;
  logic               w_cnt_zero;
  logic [CNT_W-1:0]   w_cnt_load;
  logic [DATA_W-1:0]  w_z_keep;

  assign cmd_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign w_accept   = cmd_ready && cmd_valid;
  assign w_cnt_dec  = (r_state == S_WAIT);
  assign w_capture  = w_cnt_dec && w_cnt_zero;
  assign w_rsp_hs   = rsp_valid && rsp_ready;
  assign w_cnt_load = CNT_W'(lat_for(cmd_op, ALU_LAT, MUL_LAT) - 1);
  // Only the multiply produces a high half; other opcodes report Z as zero.
  assign w_z_keep   = (alu_opcode == OP_MUL) ? alu_z : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid)  w_state_nxt = S_WAIT;
      S_WAIT:  if (w_cnt_zero) w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_hs)   w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  alu_seq_lat_cnt #(.W(CNT_W)) u_lat_cnt (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_accept),
    .i_val  (w_cnt_load),
    .i_dec  (w_cnt_dec),
    .o_zero (w_cnt_zero)
  );

  // alu_* are left at the last operation after completion to keep the ALU quiet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_data   <= '0;
      rsp_o      <= 1'b0;
      rsp_c      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        alu_opcode <= cmd_op;
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
      end
      if (w_capture) begin
        rsp_data <= {w_z_keep, alu_y};
        rsp_o    <= alu_o;
        rsp_c    <= alu_c;
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_ops <= '0;
      stat_ovf <= '0;
    end else if (w_rsp_hs) begin
      stat_ops <= stat_ops + 16'd1;
      if (rsp_o) stat_ovf <= stat_ovf + 16'd1;
    end
  end
`else
  // Statistics disabled: no counters, core path unchanged.
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized scoreboard bench for alu_op_sequencer with a latency-accurate
// main_ALU responder that shows corrupted results until its latency elapses.
module tb_alu_op_sequencer;

  localparam int DW      = 8;
  localparam int ALU_LAT = 2;
  localparam int MUL_LAT = 26;

  typedef struct {
    logic [15:0] data;
    logic        o;
    logic        c;
    int          lat;
    int          t_acc;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [DW-1:0] cmd_a = '0;
  logic [DW-1:0] cmd_b = '0;
  logic [1:0]    alu_opcode;
  logic [DW-1:0] alu_a, alu_b, alu_y, alu_z;
  logic          alu_o, alu_c;
  logic          rsp_valid, rsp_ready;
  logic [15:0]   rsp_data;
  logic          rsp_o, rsp_c;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]   stat_ops, stat_ovf;
`endif

  logic force_low = 1'b0;
  logic rand_mode = 1'b0;
  logic rnd_rdy   = 1'b1;
  assign rsp_ready = force_low ? 1'b0 : (rand_mode ? rnd_rdy : 1'b1);

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb[$];
  int   m_ops = 0;
  int   m_ovf = 0;
  bit   seen  = 1'b0;

  alu_op_sequencer #(.DATA_W(DW), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_z(alu_z), .alu_o(alu_o), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_o(rsp_o), .rsp_c(rsp_c)
`ifdef ALU_SEQ_STATS_EN
    , .stat_ops(stat_ops), .stat_ovf(stat_ovf)
`endif
  );

  initial forever #5 clock = ~clock;
  initial forever begin @(posedge clock); cyc++; end
  initial forever begin @(posedge clock); #1; rnd_rdy = ($urandom_range(0, 1) == 1); end

  // main_ALU stand-in, bit-level: returns {o,c,z,y}. Z is junk for non-multiply.
  function automatic logic [17:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  y, z;
    logic        o, c;
    o = 1'b0; c = 1'b0; y = '0; z = 8'h5A;
    case (op)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; y = s[7:0]; c = s[8]; o = (a[7] == b[7]) && (y[7] != a[7]); end
      2'b01: begin s = {1'b0, a} - {1'b0, b}; y = s[7:0]; c = s[8]; o = (a[7] != b[7]) && (y[7] != a[7]); end
      2'b10: y = a & b;
      default: begin p = 16'(a) * 16'(b); {z, y} = p; end
    endcase
    return {o, c, z, y};
  endfunction

  logic [1:0] rs_op = '0;
  logic [7:0] rs_a = '0, rs_b = '0;
  int         rs_age = 0;
  logic [17:0] rs_true;
  logic        rs_settled;

  initial forever begin
    @(negedge clock);
    if ({alu_opcode, alu_a, alu_b} != {rs_op, rs_a, rs_b}) begin
      rs_op = alu_opcode; rs_a = alu_a; rs_b = alu_b; rs_age = 0;
    end else if (rs_age < 1000) begin
      rs_age++;
    end
  end

  always_comb begin
    rs_true    = alu_fn(alu_opcode, alu_a, alu_b);
    rs_settled = ({alu_opcode, alu_a, alu_b} == {rs_op, rs_a, rs_b}) &&
                 (rs_age >= ((alu_opcode == 2'b11) ? MUL_LAT : ALU_LAT) - 1);
    {alu_o, alu_c, alu_z, alu_y} = rs_settled ? rs_true : ~rs_true;
  end

  // Reference model: plain integer arithmetic on the operation's definition.
  function automatic exp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ua, ub, sa, sb2, r;
    ua = int'(a); ub = int'(b);
    sa  = (ua > 127) ? ua - 256 : ua;
    sb2 = (ub > 127) ? ub - 256 : ub;
    e.o = 1'b0; e.c = 1'b0; e.lat = ALU_LAT; e.t_acc = 0; e.data = '0;
    case (op)
      2'b00: begin r = ua + ub; e.data = 16'(r % 256); e.c = (r > 255);
                   e.o = (sa + sb2 > 127) || (sa + sb2 < -128); end
      2'b01: begin r = ua - ub; e.data = 16'((r + 256) % 256); e.c = (ua < ub);
                   e.o = (sa - sb2 > 127) || (sa - sb2 < -128); end
      2'b10: e.data = {8'h00, a & b};
      default: begin e.data = 16'(ua * ub); e.lat = MUL_LAT; end
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm, input int act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: waited %0d cycles, required completion within bound", nm, act);
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (reset) begin
      seen = 1'b0; m_ops = 0; m_ovf = 0;
    end else if (rsp_valid) begin
      chk("busy_cmd_ready", 32'(cmd_ready), 32'h0);
      if (sb.size() == 0) begin
        chk("spurious_rsp_valid", 32'(rsp_valid), 32'h0);
      end else begin
        e = sb[0];
        if (!seen) begin
          chk("rsp_latency", 32'(cyc - e.t_acc), 32'(e.lat));
          seen = 1'b1;
        end
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_o", 32'(rsp_o), 32'(e.o));
        chk("rsp_c", 32'(rsp_c), 32'(e.c));
        if (rsp_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
          m_ops++;
          if (e.o) m_ovf++;
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, output int waited);
    exp_t e;
    bit acc;
    acc = 1'b0; waited = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    while (!acc && waited <= 300) begin
      @(negedge clock);
      if (cmd_ready) begin
        acc = 1'b1;
        e = model(op, a, b);
        e.t_acc = cyc + 1;
        sb.push_back(e);
      end else begin
        waited++;
      end
      @(posedge clock); #1;
    end
    cmd_valid = 1'b0;
    if (!acc) fail_now("cmd_accept_timeout", waited);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clock); n++; end
    while ((sb.size() != 0 || rsp_valid) && n < 2000);
    if (n >= 2000) fail_now("drain_timeout", n);
    @(posedge clock); #1;
  endtask

  int          w, n, gap;
  logic [1:0]  rop;
  logic [7:0]  ra, rb;
  logic [17:0] dir_tab [0:5];

  initial begin
    dir_tab[0] = {2'b00, 8'hFF, 8'h01};
    dir_tab[1] = {2'b01, 8'h00, 8'h01};
    dir_tab[2] = {2'b01, 8'h80, 8'h01};
    dir_tab[3] = {2'b11, 8'hFF, 8'hFF};
    dir_tab[4] = {2'b10, 8'hF0, 8'h3C};
    dir_tab[5] = {2'b00, 8'h80, 8'h80};

    repeat (2) @(posedge clock);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    send(2'b00, 8'h13, 8'h2C, w);
    wait_idle();
    chk("hold_alu_opcode", 32'(alu_opcode), 32'h0);
    chk("hold_alu_a", 32'(alu_a), 32'h13);
    chk("hold_alu_b", 32'(alu_b), 32'h2C);
    send(2'b00, 8'h7F, 8'h05, w);
    wait_idle();
    send(2'b11, 8'h04, 8'h03, w);
    wait_idle();

    force_low = 1'b1;
    send(2'b11, 8'h7F, 8'h08, w);
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clock); #1; n++; end
    if (!rsp_valid) fail_now("bp_rsp_timeout", n);
    repeat (10) begin
      @(posedge clock); #1;
      chk("bp_cmd_ready", 32'(cmd_ready), 32'h0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
    end
    force_low = 1'b0;
    wait_idle();
    chk("hold_alu_mul_a", 32'(alu_a), 32'h7F);
`ifdef ALU_SEQ_STATS_EN
    chk("stat_ops_s1to4", 32'(stat_ops), 32'd4);
    chk("stat_ovf_s1to4", 32'(stat_ovf), 32'd1);
`endif

    for (int i = 0; i < 6; i++) begin
      {rop, ra, rb} = dir_tab[i];
      send(rop, ra, rb, w);
      wait_idle();
    end

    // Reset mid-WAIT: operation must vanish and outputs clear at once.
    send(2'b01, 8'h7F, 8'h01, w);
    #2; reset = 1'b1; #1;
    sb.delete();
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_rsp_data", 32'(rsp_data), 32'h0);
    chk("midrst_rsp_oc", 32'({rsp_o, rsp_c}), 32'h0);
    chk("midrst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'h0);
`ifdef ALU_SEQ_STATS_EN
    chk("midrst_stats", 32'({stat_ops, stat_ovf}), 32'h0);
`endif
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    send(2'b10, 8'hF0, 8'h3C, w);
    chk("accept_after_reset", 32'(w), 32'h0);
    wait_idle();

    rand_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clock); #1; end
      send(rop, ra, rb, w);
      if ($urandom_range(0, 2) == 0) begin
        // Junk command while busy: must not be sampled.
        cmd_valid = 1'b1;
        cmd_op = 2'($urandom_range(0, 3));
        cmd_a  = 8'($urandom_range(0, 255));
        cmd_b  = 8'($urandom_range(0, 255));
        repeat (3) begin @(posedge clock); #1; end
        cmd_valid = 1'b0;
      end
    end
    rand_mode = 1'b0;
    wait_idle();
`ifdef ALU_SEQ_STATS_EN
    chk("stat_ops_model", 32'(stat_ops), 32'(m_ops % 65536));
    chk("stat_ovf_model", 32'(stat_ovf), 32'(m_ovf % 65536));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
